// File: rtl/cordic_prerotate.sv
// Input conditioning ahead of the first CORDIC rotation stage.
// Folds the target angle into the first quadrant by pre-rotating (x, y) by
// k*90 degrees in the same sense as the iteration chain. Output is held in a
// register, with one skid entry behind it so in_ready can come from a flop.
//
//  state | meaning
//  EMPTY | no beat held (out_valid=0, skid empty)
//  ONE   | OUT holds a beat, skid empty
//  FULL  | OUT and SKID both hold beats, input stalled
module cordic_prerotate #(
   parameter int N = 31,
   parameter int M = 31
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [N:0]   in_x,
   input  logic signed [N:0]   in_y,
   input  logic        [M:0]   in_angle,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [N:0]   out_x,
   output logic signed [N:0]   out_y,
   output logic        [M:0]   out_angle,
   output logic        [1:0]   out_quadrant,
   output logic                out_sat
);

   typedef struct packed {
      logic signed [N:0] x;
      logic signed [N:0] y;
      logic        [M:0] angle;
      logic        [1:0] quad;
      logic              sat;
   } beat_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic signed [N:0] MIN_VAL = {1'b1, {N{1'b0}}};
   localparam logic signed [N:0] MAX_VAL = {1'b0, {N{1'b1}}};

   state_t state_q, state_d;
   beat_t  out_q, out_d;
   beat_t  skid_q, skid_d;
   beat_t  xf;
   logic   ready_q;
   logic   accept;
   logic   load_out, load_skid, move_skid;
   logic   x_min, y_min;
   logic signed [N:0] neg_x, neg_y;

   assign accept = in_valid && ready_q;

   // Saturating negation: the most negative value has no positive twin.
   always_comb begin
      x_min = (in_x == MIN_VAL);
      y_min = (in_y == MIN_VAL);
      neg_x = x_min ? MAX_VAL : -in_x;
      neg_y = y_min ? MAX_VAL : -in_y;
   end

   // Quadrant fold: rotate clockwise by k*90 degrees and strip the quadrant bits.
   always_comb begin
      xf       = '0;
      xf.quad  = in_angle[M:M-1];
      xf.angle = {2'b00, in_angle[M-2:0]};
      case (in_angle[M:M-1])
         2'd0: begin
            xf.x = in_x;
            xf.y = in_y;
         end
         2'd1: begin
            xf.x   = in_y;
            xf.y   = neg_x;
            xf.sat = x_min;
         end
         2'd2: begin
            xf.x   = neg_x;
            xf.y   = neg_y;
            xf.sat = x_min | y_min;
         end
         default: begin
            xf.x   = neg_y;
            xf.y   = in_x;
            xf.sat = y_min;
         end
      endcase
   end

   // Next state and register load strobes for the output/skid pair.
   always_comb begin
      state_d   = state_q;
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               load_out = 1'b1;
               state_d  = ST_ONE;
            end
         end
         ST_ONE: begin
            if (out_ready) begin
               if (accept) load_out = 1'b1;
               else        state_d  = ST_EMPTY;
            end else if (accept) begin
               load_skid = 1'b1;
               state_d   = ST_FULL;
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               move_skid = 1'b1;
               state_d   = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Data next-values; OUT and SKID only change on their strobes.
   always_comb begin
      out_d  = out_q;
      skid_d = skid_q;
      if (load_out)       out_d = xf;
      else if (move_skid) out_d = skid_q;
      if (load_skid)      skid_d = xf;
   end

   // State, data and registered in_ready; reset drops any held beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
         ready_q <= (state_d != ST_FULL);
      end
   end

   assign in_ready     = ready_q;
   assign out_valid    = (state_q != ST_EMPTY);
   assign out_x        = out_q.x;
   assign out_y        = out_q.y;
   assign out_angle    = out_q.angle;
   assign out_quadrant = out_q.quad;
   assign out_sat      = out_q.sat;

endmodule

// File: tb/tb_cordic_prerotate.sv
// Directed bench for cordic_prerotate: vector table plus handshake sequences.
module tb_cordic_prerotate;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_x, in_y, in_angle;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_x, out_y, out_angle;
   logic [1:0]  out_quadrant;
   logic        out_sat;

   int n_checks = 0;
   int n_fail   = 0;

   cordic_prerotate #(.N(31), .M(31)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_x         (in_x),
      .in_y         (in_y),
      .in_angle     (in_angle),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_x        (out_x),
      .out_y        (out_y),
      .out_angle    (out_angle),
      .out_quadrant (out_quadrant),
      .out_sat      (out_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x, y, ang;
      logic [31:0] ex, ey, eang;
      logic [1:0]  eq;
      logic        esat;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [31:0] a);
      in_x     = x;
      in_y     = y;
      in_angle = a;
      in_valid = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{32'd1000, 32'd0, 32'h6000_0000, 32'd0, -32'sd1000, 32'h2000_0000, 2'd1, 1'b0};
      vecs[1] = '{32'd300, -32'sd200, 32'h1000_0000, 32'd300, -32'sd200, 32'h1000_0000, 2'd0, 1'b0};
      vecs[2] = '{32'd300, -32'sd200, 32'h8000_0000, -32'sd300, 32'd200, 32'h0, 2'd2, 1'b0};
      vecs[3] = '{32'd300, -32'sd200, 32'hC000_0001, 32'd200, 32'd300, 32'h1, 2'd3, 1'b0};
      vecs[4] = '{32'h8000_0000, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF, -32'sd5, 32'h0, 2'd2, 1'b1};
      vecs[5] = '{32'd7, 32'h8000_0000, 32'h4000_0003, 32'h8000_0000, -32'sd7, 32'h3, 2'd1, 1'b0};
      vecs[6] = '{32'd9, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd9, 32'h3FFF_FFFF, 2'd3, 1'b1};
      vecs[7] = '{32'h8000_0000, 32'd4, 32'h7000_0000, 32'd4, 32'h7FFF_FFFF, 32'h3000_0000, 2'd1, 1'b1};
      vecs[8] = '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h0, 2'd0, 1'b0};

      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      in_x = 32'd123; in_y = 32'd456; in_angle = 32'h4000_0000;

      // reset: outputs cleared, input blocked
      for (int c = 0; c < 2; c++) begin
         tick();
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 0);
         check("rst_out_x", out_x, 0);
         check("rst_out_y", out_y, 0);
         check("rst_out_angle", out_angle, 0);
         check("rst_out_quad", out_quadrant, 0);
         check("rst_out_sat", out_sat, 0);
      end
      rst = 1'b0; in_valid = 1'b0;
      tick();
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);

      // table vectors, back to back with out_ready high
      for (int i = 0; i < 9; i++) begin
         check("vec_in_ready", in_ready, 1);
         drive(vecs[i].x, vecs[i].y, vecs[i].ang);
         tick();
         in_valid = 1'b0;
         check("vec_out_valid", out_valid, 1);
         check("vec_out_x", out_x, vecs[i].ex);
         check("vec_out_y", out_y, vecs[i].ey);
         check("vec_out_angle", out_angle, vecs[i].eang);
         check("vec_out_quad", out_quadrant, vecs[i].eq);
         check("vec_out_sat", out_sat, vecs[i].esat);
      end
      tick();
      check("drain_out_valid", out_valid, 0);

      // backpressure: beats 0..3, out_ready low for 3 cycles after beat0
      drive(32'd10, 32'd0, 32'h0);
      tick();
      check("bp_b0_valid", out_valid, 1);
      check("bp_b0_x", out_x, 10);
      check("bp_b0_ready", in_ready, 1);
      out_ready = 1'b0;
      drive(32'd11, 32'd0, 32'h0);
      tick();
      drive(32'd12, 32'd0, 32'h0);
      check("bp_full_ready", in_ready, 0);
      check("bp_full_x", out_x, 10);
      tick();
      check("bp_hold1_ready", in_ready, 0);
      check("bp_hold1_x", out_x, 10);
      tick();
      check("bp_hold2_ready", in_ready, 0);
      check("bp_hold2_x", out_x, 10);
      check("bp_hold2_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      check("bp_b1_x", out_x, 11);
      check("bp_b1_ready", in_ready, 1);
      tick();
      check("bp_b2_x", out_x, 12);
      drive(32'd13, 32'd0, 32'h0);
      tick();
      in_valid = 1'b0;
      check("bp_b3_x", out_x, 13);
      check("bp_b3_valid", out_valid, 1);
      tick();
      check("bp_end_valid", out_valid, 0);

      // reset while FULL discards both entries
      out_ready = 1'b0;
      drive(32'd20, 32'd0, 32'h0);
      tick();
      drive(32'd21, 32'd0, 32'h0);
      tick();
      check("rf_full_ready", in_ready, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rf_rst_valid", out_valid, 0);
      check("rf_rst_ready", in_ready, 0);
      tick();
      check("rf_post_valid", out_valid, 0);
      check("rf_post_ready", in_ready, 1);
      out_ready = 1'b1;
      drive(32'd22, 32'd0, 32'h0);
      tick();
      in_valid = 1'b0;
      check("rf_new_valid", out_valid, 1);
      check("rf_new_x", out_x, 22);
      tick();
      check("rf_alone_valid", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
